bdm_byte_engine: RTL

- Byte-level BDM (Background Debug Mode) transmitter/receiver on the single-wire BKGD line.
- Sits directly downstream of the sync controller and consumes its measured sync length, i.e. host clk cycles per 128 target cycles.
- Derives per-bit timing from that measurement, then shifts one byte MSB-first to or from the target.
- The command layer above issues one byte per start.

---
 rtl/bdm_pkg.sv | 34 +++
 rtl/bdm_bit_timing.sv | 43 ++++
 rtl/bdm_byte_engine.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bdm_pkg.sv
// Shared BDM constants, FSM state encoding and a constant shift-add scaler.
// Used by the byte engine, its bit-timing helper and the command sequencer.
// No logic of its own; purely declarations.
package bdm_pkg;

  // sync_length counts clk cycles over 128 target cycles
  localparam int TCYC_SHIFT   = 7;

  // Bit-frame landmarks in target cycles
  localparam int BIT_LOW_TC   = 4;
  localparam int BIT_ZERO_TC  = 13;
  localparam int BIT_SAMP_TC  = 10;
  localparam int BIT_FRAME_TC = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    BIT_LOW     = 3'd1,
    BIT_HOLD    = 3'd2,
    BIT_SPEEDUP = 3'd3,
    BIT_WAIT    = 3'd4,
    DONE        = 3'd5
  } bdm_state_t;

  // Multiply tc by a small constant k (< 32) using shifts and adds only.
  function automatic logic [31:0] tc_scale(input logic [31:0] tc, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      if (k[i]) acc = acc + (tc << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/bdm_bit_timing.sv
// Latches per-bit timing (T_LOW/T_ZERO/T_SAMP/T_BIT) from the measured sync length.
// Latency: one cycle from load to valid outputs; values hold until the next load.
// No backpressure: load is a single-cycle strobe, outputs are static between loads.
module bdm_bit_timing
  import bdm_pkg::*;
#(
  parameter logic [24:0] MIN_TCYC = 25'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] sync_length,
  output logic [31:0] t_low,
  output logic [31:0] t_zero,
  output logic [31:0] t_samp,
  output logic [31:0] t_bit
);

  logic [24:0] tcyc_raw;
  logic [31:0] tcyc;
  logic        unused_low_bits;

  // Low bits of the sync measurement are below one target cycle and are dropped
  assign unused_low_bits = ^sync_length[TCYC_SHIFT-1:0];
  assign tcyc_raw        = sync_length[31:TCYC_SHIFT];
  assign tcyc            = {7'd0, (tcyc_raw < MIN_TCYC) ? MIN_TCYC : tcyc_raw};

  // Capture the scaled timing on start acceptance; frozen for the whole byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_low  <= '0;
      t_zero <= '0;
      t_samp <= '0;
      t_bit  <= '0;
    end else if (load) begin
      t_low  <= tc_scale(tcyc, BIT_LOW_TC);
      t_zero <= tc_scale(tcyc, BIT_ZERO_TC);
      t_samp <= tc_scale(tcyc, BIT_SAMP_TC);
      t_bit  <= tc_scale(tcyc, BIT_FRAME_TC);
    end
  end

endmodule

// File: rtl/bdm_byte_engine.sv
// Sends or receives one BDM byte MSB-first on the single-wire BKGD line.
// Latency: done pulses 8*T_BIT+1 cycles after start acceptance.
// Starts while busy are ignored; starts without a valid sync length pulse err.
module bdm_byte_engine
  import bdm_pkg::*;
#(
  parameter logic [24:0] MIN_TCYC       = 25'd1,
  parameter logic [7:0]  SPEEDUP_CYCLES = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sync_length,
  input  logic        sync_length_is_ready,
  input  logic        bkgd_in,
  output logic        bkgd_drive,
  output logic        bkgd_level,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  input  logic        rx_start,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam bit HAS_SPEEDUP = (SPEEDUP_CYCLES != 8'd0);

  bdm_state_t  state;
  logic [31:0] bc;
  logic [7:0]  sc;
  logic [2:0]  bit_idx;
  logic        is_rx;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_shift;
  logic        bkgd_meta;
  logic        bkgd_sync;
  logic        accept;
  logic [31:0] t_low;
  logic [31:0] t_zero;
  logic [31:0] t_samp;
  logic [31:0] t_bit;

  assign accept = (state == IDLE) && (tx_start || rx_start) && sync_length_is_ready;

  bdm_bit_timing #(
    .MIN_TCYC (MIN_TCYC)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .sync_length (sync_length),
    .t_low       (t_low),
    .t_zero      (t_zero),
    .t_samp      (t_samp),
    .t_bit       (t_bit)
  );

  // Two-flop synchronizer for the pin; resets high like the pulled-up line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bkgd_meta <= 1'b1;
      bkgd_sync <= 1'b1;
    end else begin
      bkgd_meta <= bkgd_in;
      bkgd_sync <= bkgd_meta;
    end
  end

  // Byte FSM: outputs are registered and set on the edge entering each phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bc         <= '0;
      sc         <= '0;
      bit_idx    <= '0;
      is_rx      <= 1'b0;
      tx_byte    <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bkgd_drive <= 1'b0;
      bkgd_level <= 1'b1;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start || rx_start) begin
            if (!sync_length_is_ready) begin
              err <= 1'b1;
            end else begin
              // tx wins a tie; the timing module loads on this same edge
              state      <= BIT_LOW;
              is_rx      <= !tx_start;
              tx_byte    <= tx_data;
              bit_idx    <= 3'd7;
              bc         <= '0;
              busy       <= 1'b1;
              bkgd_drive <= 1'b1;
              bkgd_level <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          if (state == BIT_WAIT && is_rx && bc == t_samp)
            rx_shift <= {rx_shift[6:0], bkgd_sync};
          if (bc == t_bit - 32'd1) begin
            // Frame end always wins, which also truncates an overlong speedup
            bc <= '0;
            if (bit_idx == 3'd0) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              bkgd_drive <= 1'b0;
              bkgd_level <= 1'b1;
              if (is_rx) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx - 3'd1;
              state      <= BIT_LOW;
              bkgd_drive <= 1'b1;
              bkgd_level <= 1'b0;
            end
          end else begin
            bc <= bc + 32'd1;
            case (state)
              BIT_LOW: begin
                if (bc == t_low - 32'd1) begin
                  if (!is_rx && !tx_byte[bit_idx]) begin
                    state <= BIT_HOLD;
                  end else begin
                    state      <= HAS_SPEEDUP ? BIT_SPEEDUP : BIT_WAIT;
                    bkgd_drive <= HAS_SPEEDUP;
                    bkgd_level <= 1'b1;
                    sc         <= '0;
                  end
                end
              end
              BIT_HOLD: begin
                if (bc == t_zero - 32'd1) begin
                  state      <= HAS_SPEEDUP ? BIT_SPEEDUP : BIT_WAIT;
                  bkgd_drive <= HAS_SPEEDUP;
                  bkgd_level <= 1'b1;
                  sc         <= '0;
                end
              end
              BIT_SPEEDUP: begin
                if (sc == SPEEDUP_CYCLES - 8'd1) begin
                  state      <= BIT_WAIT;
                  bkgd_drive <= 1'b0;
                end else begin
                  sc <= sc + 8'd1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
